// File: rtl/data_path_if.sv
// Control-strobe and bus bundle between the control unit (or a bench) and data_path.
// Latency: none of its own; it only carries the signals.
// Backpressure: none; every strobe is a plain per-cycle level.
//
// Ports (modport slave = datapath side):
//   Mdatain, Read, IncPC, Rin, Rout, PCin, Zin, MDRin, MARin, Yin, HIin, LOin,
//   PCout, Zhighout, Zlowout, HIout, LOout, MDRout, InPortout, opcode -> datapath
//   BusMuxOut, MARout                                                 <- datapath
interface data_path_if;
    logic [31:0] Mdatain;
    logic        Read;
    logic        IncPC;
    logic [15:0] Rin;
    logic [15:0] Rout;
    logic        PCin, Zin, MDRin, MARin, Yin, HIin, LOin;
    logic        PCout, Zhighout, Zlowout, HIout, LOout, MDRout, InPortout;
    logic [4:0]  opcode;
    logic [31:0] BusMuxOut;
    logic [31:0] MARout;

    modport master (
        output Mdatain, Read, IncPC, Rin, Rout,
        output PCin, Zin, MDRin, MARin, Yin, HIin, LOin,
        output PCout, Zhighout, Zlowout, HIout, LOout, MDRout, InPortout,
        output opcode,
        input  BusMuxOut, MARout
    );

    modport slave (
        input  Mdatain, Read, IncPC, Rin, Rout,
        input  PCin, Zin, MDRin, MARin, Yin, HIin, LOin,
        input  PCout, Zhighout, Zlowout, HIout, LOout, MDRout, InPortout,
        input  opcode,
        output BusMuxOut, MARout
    );
endinterface

// File: rtl/data_path.sv
// Phase-1 RISC datapath: R0-R15, PC, MAR, MDR, Y, Z(64), HI, LO on one 32-bit bus plus ALU.
// Latency: bus and ALU are combinational; register loads take effect on the next rising Clock.
// Backpressure: none; every transfer is a strobe that completes in the cycle it is asserted.
//
// Ports: Clock (rising edge), clear (async active-low, zeroes every register),
//        bus_if (slave side of data_path_if: control strobes, Mdatain, BusMuxOut, MARout).
module data_path (
    input  logic          Clock,
    input  logic          clear,
    data_path_if.slave    bus_if
);
    logic [31:0] r_q [16];
    logic [31:0] r_d [16];
    logic [31:0] pc_q, pc_d, mar_q, mar_d, mdr_q, mdr_d;
    logic [31:0] y_q, y_d, hi_q, hi_d, lo_q, lo_d;
    logic [63:0] z_q, z_d;

    logic [31:0] bus;
    logic [63:0] alu_c;

    // Bus encoder: sources are applied from lowest to highest priority so the
    // last matching assignment (lowest-listed source) wins.
    always_comb begin
        bus = 32'h0;
        if (bus_if.InPortout) bus = 32'h0;   // no external input port in this phase
        if (bus_if.MDRout)    bus = mdr_q;
        if (bus_if.PCout)     bus = pc_q;
        if (bus_if.Zlowout)   bus = z_q[31:0];
        if (bus_if.Zhighout)  bus = z_q[63:32];
        if (bus_if.LOout)     bus = lo_q;
        if (bus_if.HIout)     bus = hi_q;
        for (int i = 15; i >= 0; i--) begin
            if (bus_if.Rout[i]) bus = r_q[i];
        end
    end

    // ALU: A = Y, B = bus.
    logic [4:0]  shamt;
    logic [63:0] dbl_r, dbl_l, prod;
    logic [31:0] quo, rem;

    always_comb begin
        shamt = bus[4:0];
        // Rotates shift a doubled copy of A so a zero amount naturally returns A.
        dbl_r = {y_q, y_q} >> shamt;
        dbl_l = {y_q, y_q} << shamt;
        // Sign-extending to 64 bits first makes the low 64 bits of the product the signed result.
        prod  = {{32{y_q[31]}}, y_q} * {{32{bus[31]}}, bus};
        quo   = 32'h0;
        rem   = 32'h0;
        if (bus != 32'h0) begin
            quo = 32'($signed(y_q) / $signed(bus));
            rem = 32'($signed(y_q) % $signed(bus));
        end

        alu_c = 64'h0;
        if (bus_if.IncPC) begin
            alu_c = {32'h0, bus + 32'd1};
        end else begin
            case (bus_if.opcode)
                5'b00011: alu_c = {32'h0, y_q + bus};
                5'b00100: alu_c = {32'h0, y_q - bus};
                5'b00101: alu_c = {32'h0, y_q & bus};
                5'b00110: alu_c = {32'h0, y_q | bus};
                5'b00111: alu_c = {32'h0, y_q >> shamt};
                5'b01000: alu_c = {32'h0, 32'($signed(y_q) >>> shamt)};
                5'b01001: alu_c = {32'h0, y_q << shamt};
                5'b01010: alu_c = {32'h0, dbl_r[31:0]};
                5'b01011: alu_c = {32'h0, dbl_l[63:32]};
                5'b01111: alu_c = prod;
                5'b10000: alu_c = {rem, quo};
                5'b10001: alu_c = {32'h0, 32'h0 - bus};
                5'b10010: alu_c = {32'h0, ~bus};
                default:  alu_c = 64'h0;
            endcase
        end
    end

    // Next-state: every enabled register takes the bus value this cycle.
    always_comb begin
        for (int i = 0; i < 16; i++) begin
            r_d[i] = bus_if.Rin[i] ? bus : r_q[i];
        end
        pc_d  = bus_if.PCin  ? bus : pc_q;
        mar_d = bus_if.MARin ? bus : mar_q;
        mdr_d = bus_if.MDRin ? (bus_if.Read ? bus_if.Mdatain : bus) : mdr_q;
        y_d   = bus_if.Yin   ? bus : y_q;
        hi_d  = bus_if.HIin  ? bus : hi_q;
        lo_d  = bus_if.LOin  ? bus : lo_q;
        z_d   = bus_if.Zin   ? alu_c : z_q;
    end

    always_ff @(posedge Clock or negedge clear) begin
        if (!clear) begin
            for (int i = 0; i < 16; i++) r_q[i] <= 32'h0;
            pc_q  <= 32'h0;
            mar_q <= 32'h0;
            mdr_q <= 32'h0;
            y_q   <= 32'h0;
            hi_q  <= 32'h0;
            lo_q  <= 32'h0;
            z_q   <= 64'h0;
        end else begin
            for (int i = 0; i < 16; i++) r_q[i] <= r_d[i];
            pc_q  <= pc_d;
            mar_q <= mar_d;
            mdr_q <= mdr_d;
            y_q   <= y_d;
            hi_q  <= hi_d;
            lo_q  <= lo_d;
            z_q   <= z_d;
        end
    end

    assign bus_if.BusMuxOut = bus;
    assign bus_if.MARout    = mar_q;
endmodule

// File: tb/tb_data_path.sv
// Directed bench for data_path with an expected-value queue.
// Latency: expectations are pushed when an operation is driven and popped when the result is read.
// Backpressure: none; the bench drives strobes after a rising edge and samples on the falling edge.
module tb_data_path;
    logic Clock = 1'b0;
    logic clear = 1'b0;

    data_path_if dif ();

    data_path dut (
        .Clock  (Clock),
        .clear  (clear),
        .bus_if (dif)
    );

    always #5 Clock = ~Clock;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q [$];

    task automatic clr_ctl();
        dif.Read = 1'b0;  dif.IncPC = 1'b0;
        dif.Rin = '0;     dif.Rout = '0;
        dif.PCin = 1'b0;  dif.Zin = 1'b0;  dif.MDRin = 1'b0; dif.MARin = 1'b0;
        dif.Yin = 1'b0;   dif.HIin = 1'b0; dif.LOin = 1'b0;
        dif.PCout = 1'b0; dif.Zhighout = 1'b0; dif.Zlowout = 1'b0;
        dif.HIout = 1'b0; dif.LOout = 1'b0;    dif.MDRout = 1'b0; dif.InPortout = 1'b0;
        dif.opcode = 5'b00000;
    endtask

    // Let the current strobes be sampled by one rising edge, then drop them.
    task automatic tick();
        @(posedge Clock);
        #1;
        clr_ctl();
    endtask

    task automatic push_exp(input logic [31:0] v);
        exp_q.push_back(v);
    endtask

    task automatic check(input string tag, input logic [31:0] obs);
        logic [31:0] e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL %s: observed %h but no expected value queued", tag, obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e) else begin
                errors++;
                $error("FAIL %s: observed %h expected %h", tag, obs, e);
            end
        end
    endtask

    // Caller sets the bus select(s); sample the bus on the falling edge, then drop them.
    task automatic sample_bus(input string tag);
        @(negedge Clock);
        check(tag, dif.BusMuxOut);
        clr_ctl();
    endtask

    task automatic check_reg(input string tag, input int i, input logic [31:0] v);
        push_exp(v);
        dif.Rout = 16'(1) << i;
        sample_bus(tag);
    endtask

    task automatic load_reg(input int i, input logic [31:0] v);
        dif.Mdatain = v; dif.Read = 1'b1; dif.MDRin = 1'b1;
        tick();
        dif.MDRout = 1'b1; dif.Rin = 16'(1) << i;
        tick();
    endtask

    // Y <- a, then Z <- ALU(op, Y, b); both operands routed through MDR.
    task automatic alu_direct(input logic [31:0] a, input logic [31:0] b, input logic [4:0] op);
        dif.Mdatain = a; dif.Read = 1'b1; dif.MDRin = 1'b1;
        tick();
        dif.MDRout = 1'b1; dif.Yin = 1'b1;
        tick();
        dif.Mdatain = b; dif.Read = 1'b1; dif.MDRin = 1'b1;
        tick();
        dif.MDRout = 1'b1; dif.Zin = 1'b1; dif.opcode = op;
        tick();
    endtask

    task automatic run_vec(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] op, input logic [31:0] lo, input logic [31:0] hi);
        alu_direct(a, b, op);
        push_exp(lo);
        push_exp(hi);
        dif.Zlowout = 1'b1;
        sample_bus({tag, "_lo"});
        dif.Zhighout = 1'b1;
        sample_bus({tag, "_hi"});
    endtask

    initial begin
        dif.Mdatain = 32'h0;
        clr_ctl();

        // Reset state while clear is held low.
        #2;
        check_reg("rst_r0", 0, 32'h0);
        push_exp(32'h0); dif.Zhighout = 1'b1; sample_bus("rst_zhigh");
        push_exp(32'h0); check("rst_mar", dif.MARout);
        push_exp(32'h0); sample_bus("rst_idle");
        #3;
        clear = 1'b1;
        @(posedge Clock); #1;

        // Register load through MDR, bus value while MDRout is driving.
        dif.Mdatain = 32'h12; dif.Read = 1'b1; dif.MDRin = 1'b1;
        tick();
        dif.MDRout = 1'b1; dif.Rin = 16'(1) << 3;
        push_exp(32'h12);
        @(negedge Clock); check("mdr_bus", dif.BusMuxOut);
        tick();
        check_reg("r3_load", 3, 32'h12);

        // shra via register file: R1 = R3 >>> R5.
        load_reg(5, 32'h14);
        dif.Rout = 16'(1) << 3; dif.Yin = 1'b1; tick();
        dif.Rout = 16'(1) << 5; dif.Zin = 1'b1; dif.opcode = 5'b01000; tick();
        dif.Zlowout = 1'b1; dif.Rin = 16'(1) << 1; tick();
        check_reg("shra_pos", 1, 32'h0);
        load_reg(3, 32'h8000_0000);
        load_reg(5, 32'h4);
        dif.Rout = 16'(1) << 3; dif.Yin = 1'b1; tick();
        dif.Rout = 16'(1) << 5; dif.Zin = 1'b1; dif.opcode = 5'b01000; tick();
        dif.Zlowout = 1'b1; dif.Rin = 16'(1) << 1; tick();
        check_reg("shra_neg", 1, 32'hF800_0000);

        // PC increment with opcode ignored.
        dif.Mdatain = 32'h5; dif.Read = 1'b1; dif.MDRin = 1'b1; tick();
        dif.MDRout = 1'b1; dif.PCin = 1'b1; tick();
        dif.PCout = 1'b1; dif.MARin = 1'b1; dif.IncPC = 1'b1; dif.Zin = 1'b1; tick();
        dif.Zlowout = 1'b1; dif.PCin = 1'b1; tick();
        push_exp(32'h5); check("mar_pc", dif.MARout);
        push_exp(32'h6); dif.PCout = 1'b1; sample_bus("pc_inc");

        // mul / div with Y = -3, B = 7.
        load_reg(4, 32'hFFFF_FFFD);
        load_reg(6, 32'h7);
        dif.Rout = 16'(1) << 4; dif.Yin = 1'b1; tick();
        dif.Rout = 16'(1) << 6; dif.Zin = 1'b1; dif.opcode = 5'b01111; tick();
        dif.Zhighout = 1'b1; dif.HIin = 1'b1; tick();
        dif.Zlowout = 1'b1; dif.LOin = 1'b1; tick();
        push_exp(32'hFFFF_FFFF); dif.HIout = 1'b1; sample_bus("mul_hi");
        push_exp(32'hFFFF_FFEB); dif.LOout = 1'b1; sample_bus("mul_lo");
        dif.Rout = 16'(1) << 6; dif.Zin = 1'b1; dif.opcode = 5'b10000; tick();
        push_exp(32'h0);         dif.Zlowout = 1'b1;  sample_bus("div_quo");
        push_exp(32'hFFFF_FFFD); dif.Zhighout = 1'b1; sample_bus("div_rem");
        run_vec("div0", 32'h1234_5678, 32'h0, 5'b10000, 32'h0, 32'h0);
        run_vec("div_pos", 32'd100, 32'hFFFF_FFF9, 5'b10000, 32'hFFFF_FFF2, 32'h2);

        // Remaining opcodes, shift-amount masking and undefined code.
        run_vec("add", 32'h0000_00F0, 32'h0000_000F, 5'b00011, 32'h0000_00FF, 32'h0);
        run_vec("add_wrap", 32'hFFFF_FFFF, 32'h2, 5'b00011, 32'h1, 32'h0);
        run_vec("sub", 32'h0000_00F0, 32'h0000_000F, 5'b00100, 32'h0000_00E1, 32'h0);
        run_vec("and", 32'h0000_00F0, 32'h0000_003F, 5'b00101, 32'h0000_0030, 32'h0);
        run_vec("or",  32'h0000_00F0, 32'h0000_000F, 5'b00110, 32'h0000_00FF, 32'h0);
        run_vec("shr", 32'h8000_0001, 32'h24, 5'b00111, 32'h0800_0000, 32'h0);
        run_vec("shl", 32'h8000_0001, 32'h24, 5'b01001, 32'h0000_0010, 32'h0);
        run_vec("ror", 32'h8000_0001, 32'h24, 5'b01010, 32'h1800_0000, 32'h0);
        run_vec("rol", 32'h8000_0001, 32'h24, 5'b01011, 32'h0000_0018, 32'h0);
        run_vec("ror0", 32'h8000_0001, 32'h20, 5'b01010, 32'h8000_0001, 32'h0);
        run_vec("neg", 32'h0, 32'h5, 5'b10001, 32'hFFFF_FFFB, 32'h0);
        run_vec("not", 32'h0, 32'h0F0F_0F0F, 5'b10010, 32'hF0F0_F0F0, 32'h0);
        run_vec("undef", 32'h1, 32'h1, 5'b11111, 32'h0, 32'h0);

        // Bus priority, idle bus, self-reload, MDR from bus, multi-load.
        load_reg(2, 32'hA5A5_0002);
        push_exp(32'hA5A5_0002); dif.Rout = 16'(1) << 2; dif.PCout = 1'b1; sample_bus("prio_r2_pc");
        push_exp(32'h6); dif.PCout = 1'b1; dif.MDRout = 1'b1; sample_bus("prio_pc_mdr");
        push_exp(32'h0); sample_bus("idle_bus");
        dif.Rout = 16'(1) << 3; dif.Rin = 16'(1) << 3; tick();
        check_reg("self_reload", 3, 32'h8000_0000);
        dif.Rout = 16'(1) << 2; dif.MDRin = 1'b1; dif.Read = 1'b0;
        dif.Rin = (16'(1) << 8) | (16'(1) << 9); tick();
        push_exp(32'hA5A5_0002); dif.MDRout = 1'b1; sample_bus("mdr_from_bus");
        check_reg("multi_r8", 8, 32'hA5A5_0002);
        check_reg("multi_r9", 9, 32'hA5A5_0002);

        // Reset mid-operation, between clock edges.
        load_reg(1, 32'hDEAD_BEEF);
        run_vec("pre_rst", 32'h1, 32'h2, 5'b00011, 32'h3, 32'h0);
        @(posedge Clock); #2;
        clear = 1'b0;
        check_reg("rst_r1", 1, 32'h0);
        push_exp(32'h0); dif.PCout = 1'b1;   sample_bus("rst_pc");
        push_exp(32'h0); dif.Zlowout = 1'b1; sample_bus("rst_zlow");
        push_exp(32'h0); check("rst_mar2", dif.MARout);
        #1;
        clear = 1'b1;
        load_reg(1, 32'h0000_0077);
        check_reg("post_rst_r1", 1, 32'h0000_0077);

        if (exp_q.size() != 0) begin
            errors++;
            $error("FAIL leftover_queue: observed %0d entries expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
